// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Refills a 4-word line over a single-beat backing-memory port; stores go straight through.
module data_cache #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_SETS       = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            AddressingControlM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallMem,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned IdxW = $clog2(NUM_SETS);
    localparam int unsigned TagW = DATA_WIDTH - 4 - IdxW;

    typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [NUM_SETS-1:0]   valid_q;
    logic [TagW-1:0]       tag_q  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_q [NUM_SETS][WORDS_PER_LINE];

    logic [TagW-1:0]       addr_tag;
    logic [IdxW-1:0]       addr_idx;
    logic [1:0]            word_sel;
    logic [1:0]            offset;
    logic                  hit;
    logic [DATA_WIDTH-1:0] line_word;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic [3:0]            strb;
    logic                  fill_en;
    logic                  store_en;
    logic                  clr_valid;

    assign addr_tag  = ALUResultM[DATA_WIDTH-1 -: TagW];
    assign addr_idx  = ALUResultM[4 +: IdxW];
    assign word_sel  = ALUResultM[3:2];
    assign offset    = ALUResultM[1:0];
    assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign line_word = data_q[addr_idx][word_sel];

    // Load lane selection and sign/zero extension
    always_comb begin
        case (offset)
            2'd0:    byte_lane = line_word[7:0];
            2'd1:    byte_lane = line_word[15:8];
            2'd2:    byte_lane = line_word[23:16];
            default: byte_lane = line_word[31:24];
        endcase
        half_lane = offset[1] ? line_word[31:16] : line_word[15:0];
        case (AddressingControlM)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'h0, byte_lane};
            3'b101:  load_data = {16'h0, half_lane};
            default: load_data = line_word;
        endcase
    end

    // Store data replicated across lanes so the strobe alone picks the bytes
    always_comb begin
        case (AddressingControlM[1:0])
            2'b00: begin
                strb      = 4'b0001 << offset;
                mem_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                strb      = offset[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                mem_wdata = WriteDataM;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        StallMem  = 1'b0;
        ReadDataM = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
        mem_wstrb = 4'b0000;
        fill_en   = 1'b0;
        store_en  = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            StIdle: begin
                if (MemWriteM) begin
                    StallMem = 1'b1;
                    state_d  = StWrite;
                end else if (MemReadM) begin
                    if (hit) begin
                        ReadDataM = load_data;
                    end else begin
                        StallMem  = 1'b1;
                        clr_valid = 1'b1;
                        cnt_d     = 2'd0;
                        state_d   = StRefill;
                    end
                end
            end
            StRefill: begin
                StallMem = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {ALUResultM[DATA_WIDTH-1:4], cnt_q, 2'b00};
                if (mem_ready) begin
                    fill_en = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StIdle;
                end
            end
            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wstrb = strb;
                if (mem_ready) begin
                    store_en = hit;
                    state_d  = StIdle;
                end else begin
                    StallMem = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (clr_valid) valid_q[addr_idx] <= 1'b0;
            if (fill_en && cnt_q == 2'd3) valid_q[addr_idx] <= 1'b1;
        end
    end

    // Line data and tags need no reset; validity alone guards them
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[addr_idx][cnt_q] <= mem_rdata;
            if (cnt_q == 2'd3) tag_q[addr_idx] <= addr_tag;
        end
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) data_q[addr_idx][word_sel][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: a backing-memory model with programmable ready delay,
// and scoreboards of expected memory beats and load results.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  AddressingControlM;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem_model [0:1023];
    int          ready_delay;
    int          wait_cnt;
    int          n_tests;
    int          n_fail;

    data_cache dut (
        .clk                (clk),
        .rst                (rst),
        .ALUResultM         (ALUResultM),
        .WriteDataM         (WriteDataM),
        .MemWriteM          (MemWriteM),
        .MemReadM           (MemReadM),
        .AddressingControlM (AddressingControlM),
        .ReadDataM          (ReadDataM),
        .StallMem           (StallMem),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wstrb          (mem_wstrb),
        .mem_ready          (mem_ready),
        .mem_rdata          (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = mem_req && (wait_cnt >= ready_delay);
    assign mem_rdata = mem_model[mem_addr[11:2]];

    always @(posedge clk) wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Memory side: every accepted beat is checked against the expected-beat queue
    always @(negedge clk) begin : mem_monitor
        beat_t b;
        if (mem_req && mem_ready) begin
            if (beat_q.size() == 0) begin
                check_eq("beat_queue_nonempty", 32'(beat_q.size()), 32'd1);
            end else begin
                b = beat_q.pop_front();
                check_eq("beat_addr", mem_addr, b.addr);
                check_eq("beat_we", 32'(mem_we), 32'(b.we));
                if (b.we) begin
                    check_eq("beat_wdata", mem_wdata, b.wdata);
                    check_eq("beat_wstrb", 32'(mem_wstrb), 32'(b.strb));
                end
            end
            if (mem_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_wstrb[i]) mem_model[mem_addr[11:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
        end
    end

    task automatic push_refill(input logic [31:0] addr);
        for (int i = 0; i < 4; i++) begin
            beat_q.push_back('{we: 1'b0, addr: {addr[31:4], 2'(i), 2'b00}, wdata: 32'h0,
                               strb: 4'h0});
        end
    endtask

    task automatic push_store(input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] st);
        beat_q.push_back('{we: 1'b1, addr: {addr[31:2], 2'b00}, wdata: wd, strb: st});
    endtask

    // Drive one access, hold it while stalled, then check stall length and load result
    task automatic access(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_stall,
                          input logic [31:0] exp_rd, input string name);
        int stalls;
        bit done;
        stalls = 0;
        done = 1'b0;
        ALUResultM = addr;
        WriteDataM = wd;
        AddressingControlM = ctrl;
        MemWriteM = wr;
        MemReadM = !wr;
        if (!wr) rd_q.push_back(exp_rd);
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (StallMem) begin
                stalls++;
                if (!wr) check_eq({name, "_rd_during_stall"}, ReadDataM, 32'h0);
            end else begin
                done = 1'b1;
                if (!wr) begin
                    check_eq({name, "_rdata"}, ReadDataM, rd_q.pop_front());
                    check_eq({name, "_req_on_hit"}, 32'(mem_req), 32'd0);
                end
            end
            @(posedge clk);
            #1;
        end
        check_eq({name, "_completed"}, 32'(done), 32'd1);
        check_eq({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        MemWriteM = 1'b0;
        MemReadM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        ready_delay = 0;
        wait_cnt = 0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_model[(32'h100 >> 2) + i] = 32'h11 * (i + 1);
            mem_model[(32'h200 >> 2) + i] = 32'hA0 + i;
            mem_model[(32'h140 >> 2) + i] = 32'hCAFE0140 + 4 * i;
            mem_model[(32'h180 >> 2) + i] = 32'hBEEF0180 + 4 * i;
        end
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        AddressingControlM = 3'b010;
        MemWriteM = 1'b0;
        MemReadM = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check_eq("reset_stall", 32'(StallMem), 32'd0);
        check_eq("reset_req", 32'(mem_req), 32'd0);
        check_eq("reset_we", 32'(mem_we), 32'd0);
        check_eq("reset_wstrb", 32'(mem_wstrb), 32'd0);
        check_eq("reset_rdata", ReadDataM, 32'h0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        push_refill(32'h100);
        access(1'b0, 3'b010, 32'h100, 32'h0, 5, 32'h00000011, "lw100_miss");
        access(1'b0, 3'b010, 32'h108, 32'h0, 0, 32'h00000033, "lw108_hit");

        push_store(32'h100, 32'h000080FF, 4'b1111);
        access(1'b1, 3'b010, 32'h100, 32'h000080FF, 1, 32'h0, "sw100_hit");
        access(1'b0, 3'b000, 32'h100, 32'h0, 0, 32'hFFFFFFFF, "lb100");
        access(1'b0, 3'b100, 32'h101, 32'h0, 0, 32'h00000080, "lbu101");
        access(1'b0, 3'b001, 32'h100, 32'h0, 0, 32'hFFFF80FF, "lh100");
        access(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h00000000, "lhu102");
        access(1'b0, 3'b000, 32'h101, 32'h0, 0, 32'hFFFFFF80, "lb101");

        ready_delay = 3;
        push_store(32'h102, 32'hABABABAB, 4'b0100);
        access(1'b1, 3'b000, 32'h102, 32'h000000AB, 4, 32'h0, "sb102_slow");
        ready_delay = 0;
        access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h00AB80FF, "lw100_after_sb");
        access(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h000000AB, "lhu102_after_sb");

        push_store(32'h10E, 32'h12341234, 4'b1100);
        access(1'b1, 3'b001, 32'h10E, 32'h00001234, 1, 32'h0, "sh10e");
        access(1'b0, 3'b010, 32'h10C, 32'h0, 0, 32'h12340044, "lw10c_after_sh");

        push_refill(32'h200);
        access(1'b0, 3'b010, 32'h200, 32'h0, 5, 32'h000000A0, "lw200_conflict");
        push_refill(32'h100);
        access(1'b0, 3'b010, 32'h100, 32'h0, 5, 32'h00AB80FF, "lw100_remiss");

        push_store(32'h300, 32'hDEAD0300, 4'b1111);
        access(1'b1, 3'b010, 32'h300, 32'hDEAD0300, 1, 32'h0, "sw300_miss");
        access(1'b0, 3'b010, 32'h10C, 32'h0, 0, 32'h12340044, "lw10c_after_miss_store");
        push_refill(32'h300);
        access(1'b0, 3'b010, 32'h300, 32'h0, 5, 32'hDEAD0300, "lw300_no_allocate");

        ready_delay = 2;
        push_refill(32'h140);
        access(1'b0, 3'b010, 32'h144, 32'h0, 13, 32'hCAFE0144, "lw144_slow_refill");
        ready_delay = 0;

        // Reset after the second refill beat
        ALUResultM = 32'h18C;
        AddressingControlM = 3'b010;
        MemReadM = 1'b1;
        beat_q.push_back('{we: 1'b0, addr: 32'h180, wdata: 32'h0, strb: 4'h0});
        beat_q.push_back('{we: 1'b0, addr: 32'h184, wdata: 32'h0, strb: 4'h0});
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        MemReadM = 1'b0;
        #1;
        check_eq("midreset_req", 32'(mem_req), 32'd0);
        check_eq("midreset_stall", 32'(StallMem), 32'd0);
        check_eq("midreset_beats_left", 32'(beat_q.size()), 32'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        push_refill(32'h100);
        access(1'b0, 3'b010, 32'h100, 32'h0, 5, 32'h00AB80FF, "lw100_after_reset");
        push_refill(32'h180);
        access(1'b0, 3'b010, 32'h18C, 32'h0, 5, 32'hBEEF018C, "lw18c_full_refill");
        access(1'b0, 3'b010, 32'h184, 32'h0, 0, 32'hBEEF0184, "lw184_hit");

        repeat (2) @(negedge clk);
        check_eq("final_beats_left", 32'(beat_q.size()), 32'd0);
        check_eq("idle_req", 32'(mem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
